// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: field widths, load-type
// bit layouts, write-back select bits, FSM encodings and the stage payload.
package mem_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned WNUM_W   = 5;
    localparam int unsigned WTYPE_W  = 3;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned LUBHW_W  = 5;
    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned STATE_W  = 2;

    // lubhw_con one-hot bit positions
    localparam int unsigned LUBHW_LB  = 0;
    localparam int unsigned LUBHW_LBU = 1;
    localparam int unsigned LUBHW_LH  = 2;
    localparam int unsigned LUBHW_LHU = 3;
    localparam int unsigned LUBHW_LW  = 4;

    // onehot layout: [3:0] LWL offset 0..3, [7:4] LWR offset 0..3
    localparam int unsigned ONEHOT_LWL_LO = 0;
    localparam int unsigned ONEHOT_LWR_LO = 4;

    // sel_wbdata bit positions
    localparam int unsigned SEL_ALU  = 0;
    localparam int unsigned SEL_LOAD = 1;
    localparam int unsigned SEL_NNPC = 2;
    localparam int unsigned SEL_RSVD = 3;

    // Load-tracking FSM encodings
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;

    // Payload carried from EXE into the MEM stage register
    typedef struct packed {
        logic [DATA_W-1:0]  alures;
        logic [SEL_W-1:0]   sel_wbdata;
        logic [LUBHW_W-1:0] lubhw_con;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  nnpc;
        logic [WNUM_W-1:0]  wnum;
        logic [WTYPE_W-1:0] write_type;
    } mem_stage_t;

    // Byte lane select from a 32-bit word
    function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                             input logic [1:0]        idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extraction: byte/half/word select with sign or zero extension,
// plus the little-endian LWL/LWR merge with the old rt value.
module load_ext
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0]   raw_data,
    input  logic [1:0]          addr,
    input  logic [LUBHW_W-1:0]  lubhw_con,
    input  logic [ONEHOT_W-1:0] onehot,
    input  logic [DATA_W-1:0]   rt,
    output logic [DATA_W-1:0]   result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Extend the selected lane, or merge partial words for LWL/LWR
    always_comb begin
        byte_sel = pick_byte(raw_data, addr);
        half_sel = addr[1] ? raw_data[31:16] : raw_data[15:0];
        result   = '0;
        if (lubhw_con[LUBHW_LB])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (lubhw_con[LUBHW_LBU])
            result = {24'b0, byte_sel};
        else if (lubhw_con[LUBHW_LH])
            result = {{16{half_sel[15]}}, half_sel};
        else if (lubhw_con[LUBHW_LHU])
            result = {16'b0, half_sel};
        else if (lubhw_con[LUBHW_LW])
            result = raw_data;
        else if (onehot[ONEHOT_LWL_LO + 0])
            result = {raw_data[7:0], rt[23:0]};
        else if (onehot[ONEHOT_LWL_LO + 1])
            result = {raw_data[15:0], rt[15:0]};
        else if (onehot[ONEHOT_LWL_LO + 2])
            result = {raw_data[23:0], rt[7:0]};
        else if (onehot[ONEHOT_LWL_LO + 3])
            result = raw_data;
        else if (onehot[ONEHOT_LWR_LO + 0])
            result = raw_data;
        else if (onehot[ONEHOT_LWR_LO + 1])
            result = {rt[31:24], raw_data[31:8]};
        else if (onehot[ONEHOT_LWR_LO + 2])
            result = {rt[31:16], raw_data[31:16]};
        else if (onehot[ONEHOT_LWR_LO + 3])
            result = {rt[31:8], raw_data[31:24]};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for the data-memory
// response of loads, and produces write-back data.
// Build option: define MEM_LWLR_EN to enable LWL/LWR merge support.
module mem_stage
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exe_valid_in,
    output logic                mem_allowin_out,
    input  logic                wb_allowin_in,
    output logic                mem_valid_out,
    input  logic [DATA_W-1:0]   exe_alures_in,
    input  logic [SEL_W-1:0]    exe_sel_wbdata_in,
    input  logic [LUBHW_W-1:0]  exe_lubhw_con_in,
    input  logic [ONEHOT_W-1:0] exe_onehot_in,
    input  logic [DATA_W-1:0]   exe_rt_in,
    input  logic [DATA_W-1:0]   exe_PC_in,
    input  logic [DATA_W-1:0]   exe_NNPC_in,
    input  logic [WNUM_W-1:0]   exe_wnum_in,
    input  logic [WTYPE_W-1:0]  exe_write_type_in,
    input  logic                dm_data_ok_in,
    input  logic [DATA_W-1:0]   dm_rdata_in,
    output logic [DATA_W-1:0]   mem_wbdata_out,
    output logic [WNUM_W-1:0]   mem_wnum_out,
    output logic [WTYPE_W-1:0]  mem_write_type_out,
    output logic [DATA_W-1:0]   mem_PC_out,
    output logic                mem_load_busy_out
);

    mem_stage_t           stage_r;
    logic                 valid_r;
    logic [STATE_W-1:0]   state_r;
    logic [STATE_W-1:0]   state_nxt;
    logic [DATA_W-1:0]    rdata_r;

    logic [ONEHOT_W-1:0]  onehot_q;
    logic [DATA_W-1:0]    rt_q;
    logic                 exe_onehot_nz;

    logic                 latch_c;
    logic                 latch_load_c;
    logic                 is_load_c;
    logic                 data_now_c;
    logic                 ready_c;
    logic [DATA_W-1:0]    load_raw_c;
    logic [DATA_W-1:0]    load_data_c;
    logic [DATA_W-1:0]    wbdata_c;

`ifdef MEM_LWLR_EN
    logic [ONEHOT_W-1:0]  onehot_r;
    logic [DATA_W-1:0]    rt_r;

    // LWL/LWR controls and the old rt value travel with the instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onehot_r <= '0;
            rt_r     <= '0;
        end else if (latch_c) begin
            onehot_r <= exe_onehot_in;
            rt_r     <= exe_rt_in;
        end
    end

    assign onehot_q      = onehot_r;
    assign rt_q          = rt_r;
    assign exe_onehot_nz = |exe_onehot_in;
`else
    logic unused_lwlr;

    assign onehot_q      = '0;
    assign rt_q          = '0;
    assign exe_onehot_nz = 1'b0;
    assign unused_lwlr   = ^{exe_onehot_in, exe_rt_in};
`endif

    assign latch_c      = mem_allowin_out && exe_valid_in;
    assign latch_load_c = latch_c && ((|exe_lubhw_con_in) || exe_onehot_nz);
    assign is_load_c    = (|stage_r.lubhw_con) || (|onehot_q);
    assign data_now_c   = (state_r == ST_WAIT) && dm_data_ok_in;
    assign ready_c      = !is_load_c || (state_r == ST_HOLD) || data_now_c;

    assign mem_valid_out     = valid_r && ready_c;
    assign mem_allowin_out   = !valid_r || (ready_c && wb_allowin_in);
    assign mem_load_busy_out = valid_r && is_load_c && !ready_c;

    // Stage payload register
    always_ff @(posedge clk) begin
        if (!rst_n)
            stage_r <= '0;
        else if (latch_c)
            stage_r <= '{alures:     exe_alures_in,
                         sel_wbdata: exe_sel_wbdata_in,
                         lubhw_con:  exe_lubhw_con_in,
                         pc:         exe_PC_in,
                         nnpc:       exe_NNPC_in,
                         wnum:       exe_wnum_in,
                         write_type: exe_write_type_in};
    end

    // Stage occupancy
    always_ff @(posedge clk) begin
        if (!rst_n)
            valid_r <= 1'b0;
        else if (mem_allowin_out)
            valid_r <= exe_valid_in;
        else if (wb_allowin_in && mem_valid_out && !exe_valid_in)
            valid_r <= 1'b0;
    end

    // Response buffer for loads that complete while WB is stalled
    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata_r <= '0;
        else if (data_now_c)
            rdata_r <= dm_rdata_in;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_r <= ST_IDLE;
        else
            state_r <= state_nxt;
    end

    // FSM next state: wait for data_ok, park in HOLD while WB is stalled
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (latch_load_c)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (dm_data_ok_in) begin
                    if (wb_allowin_in)
                        state_nxt = latch_load_c ? ST_WAIT : ST_IDLE;
                    else
                        state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wb_allowin_in)
                    state_nxt = latch_load_c ? ST_WAIT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load_raw_c = data_now_c ? dm_rdata_in : rdata_r;

    load_ext u_load_ext (
        .raw_data  (load_raw_c),
        .addr      (stage_r.alures[1:0]),
        .lubhw_con (stage_r.lubhw_con),
        .onehot    (onehot_q),
        .rt        (rt_q),
        .result    (load_data_c)
    );

    // Write-back data select; reserved select yields zero
    always_comb begin
        wbdata_c = '0;
        if (stage_r.sel_wbdata[SEL_ALU])
            wbdata_c = stage_r.alures;
        else if (stage_r.sel_wbdata[SEL_LOAD])
            wbdata_c = load_data_c;
        else if (stage_r.sel_wbdata[SEL_NNPC])
            wbdata_c = stage_r.nnpc;
        else if (stage_r.sel_wbdata[SEL_RSVD])
            wbdata_c = '0;
    end

    assign mem_wbdata_out     = wbdata_c;
    assign mem_wnum_out       = valid_r ? stage_r.wnum : '0;
    assign mem_write_type_out = valid_r ? stage_r.write_type : '0;
    assign mem_PC_out         = stage_r.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// back-to-back stream, with expected write-backs queued in a scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid_in;
    logic        mem_allowin_out;
    logic        wb_allowin_in;
    logic        mem_valid_out;
    logic [31:0] exe_alures_in;
    logic [3:0]  exe_sel_wbdata_in;
    logic [4:0]  exe_lubhw_con_in;
    logic [7:0]  exe_onehot_in;
    logic [31:0] exe_rt_in;
    logic [31:0] exe_PC_in;
    logic [31:0] exe_NNPC_in;
    logic [4:0]  exe_wnum_in;
    logic [2:0]  exe_write_type_in;
    logic        dm_data_ok_in;
    logic [31:0] dm_rdata_in;
    logic [31:0] mem_wbdata_out;
    logic [4:0]  mem_wnum_out;
    logic [2:0]  mem_write_type_out;
    logic [31:0] mem_PC_out;
    logic        mem_load_busy_out;

    typedef struct packed {
        logic [31:0] wbdata;
        logic [4:0]  wnum;
        logic [2:0]  wtype;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .exe_valid_in       (exe_valid_in),
        .mem_allowin_out    (mem_allowin_out),
        .wb_allowin_in      (wb_allowin_in),
        .mem_valid_out      (mem_valid_out),
        .exe_alures_in      (exe_alures_in),
        .exe_sel_wbdata_in  (exe_sel_wbdata_in),
        .exe_lubhw_con_in   (exe_lubhw_con_in),
        .exe_onehot_in      (exe_onehot_in),
        .exe_rt_in          (exe_rt_in),
        .exe_PC_in          (exe_PC_in),
        .exe_NNPC_in        (exe_NNPC_in),
        .exe_wnum_in        (exe_wnum_in),
        .exe_write_type_in  (exe_write_type_in),
        .dm_data_ok_in      (dm_data_ok_in),
        .dm_rdata_in        (dm_rdata_in),
        .mem_wbdata_out     (mem_wbdata_out),
        .mem_wnum_out       (mem_wnum_out),
        .mem_write_type_out (mem_write_type_out),
        .mem_PC_out         (mem_PC_out),
        .mem_load_busy_out  (mem_load_busy_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_valid_in      = 1'b0;
        exe_alures_in     = '0;
        exe_sel_wbdata_in = '0;
        exe_lubhw_con_in  = '0;
        exe_onehot_in     = '0;
        exe_rt_in         = '0;
        exe_PC_in         = '0;
        exe_NNPC_in       = '0;
        exe_wnum_in       = '0;
        exe_write_type_in = '0;
        dm_data_ok_in     = 1'b0;
        dm_rdata_in       = '0;
        wb_allowin_in     = 1'b1;
    endtask

    task automatic issue(input logic [31:0] alures, input logic [3:0] sel,
                         input logic [4:0] lubhw, input logic [7:0] onehot,
                         input logic [31:0] rt, input logic [31:0] pc,
                         input logic [4:0] wnum, input logic [2:0] wtype);
        exe_valid_in      = 1'b1;
        exe_alures_in     = alures;
        exe_sel_wbdata_in = sel;
        exe_lubhw_con_in  = lubhw;
        exe_onehot_in     = onehot;
        exe_rt_in         = rt;
        exe_PC_in         = pc;
        exe_NNPC_in       = pc + 32'd8;
        exe_wnum_in       = wnum;
        exe_write_type_in = wtype;
    endtask

    function automatic exp_t observed();
        return '{wbdata: mem_wbdata_out, wnum: mem_wnum_out,
                 wtype: mem_write_type_out, pc: mem_PC_out};
    endfunction

    // Reference extension model, written with shifts rather than lane muxes
    function automatic logic [31:0] ext_model(input logic [4:0] lubhw,
                                              input logic [1:0] addr,
                                              input logic [31:0] rd);
        logic [31:0] sb_w;
        logic [31:0] sh_w;
        sb_w = rd >> {addr, 3'b000};
        sh_w = rd >> {addr[1], 4'b0000};
        case (lubhw)
            5'b00001: return {{24{sb_w[7]}}, sb_w[7:0]};
            5'b00010: return {24'b0, sb_w[7:0]};
            5'b00100: return {{16{sh_w[15]}}, sh_w[15:0]};
            5'b01000: return {16'b0, sh_w[15:0]};
            default:  return rd;
        endcase
    endfunction

    task automatic test_reset();
        exp_t got;
        idle_inputs();
        rst_n = 1'b0;
        issue(32'hFFFF_FFFF, 4'b0001, 5'b10000, 8'h00, 32'h0, 32'h1111_0000, 5'd7, 3'd5);
        tick();
        tick();
        got = observed();
        checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_valid_out); end
        checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", mem_allowin_out); end
        checks++; if (mem_load_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mem_load_busy_out); end
        checks++; if (got !== exp_t'(0)) begin errors++; $display("FAIL reset_outputs: got %h want 0", got); end
        exe_valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        exp_t e;
        issue(32'h0000_1234, 4'b0001, 5'b0, 8'h0, 32'h0, 32'h0000_0100, 5'd3, 3'd1);
        sb.push_back('{wbdata: 32'h0000_1234, wnum: 5'd3, wtype: 3'd1, pc: 32'h0000_0100});
        #1;
        checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL alu_allowin: got %b want 1", mem_allowin_out); end
        tick();
        exe_valid_in = 1'b0;
        #1;
        checks++; if (mem_valid_out !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b want 1", mem_valid_out); end
        e = sb.pop_front();
        checks++; if (observed() !== e) begin errors++; $display("FAIL alu_wb: got %h want %h", observed(), e); end
        tick();
        checks++; if (mem_valid_out !== 1'b0 || mem_wnum_out !== 5'd0) begin errors++; $display("FAIL alu_drain: got valid=%b wnum=%0d want 0/0", mem_valid_out, mem_wnum_out); end
    endtask

    task automatic test_lb();
        logic [4:0]  kind [2];
        logic [31:0] want [2];
        exp_t e;
        kind[0] = 5'b00001; want[0] = 32'hFFFF_FFFF;
        kind[1] = 5'b00010; want[1] = 32'h0000_00FF;
        for (int i = 0; i < 2; i++) begin
            issue(32'h0000_1002, 4'b0010, kind[i], 8'h0, 32'h0, 32'h0000_0200 + 32'(i * 4), 5'd4, 3'd2);
            sb.push_back('{wbdata: want[i], wnum: 5'd4, wtype: 3'd2, pc: 32'h0000_0200 + 32'(i * 4)});
            tick();
            exe_valid_in  = 1'b0;
            dm_data_ok_in = 1'b1;
            dm_rdata_in   = 32'h80FF_0000;
            #1;
            checks++; if (mem_valid_out !== 1'b1 || mem_load_busy_out !== 1'b0) begin errors++; $display("FAIL lb_same_cycle[%0d]: got valid=%b busy=%b want 1/0", i, mem_valid_out, mem_load_busy_out); end
            e = sb.pop_front();
            checks++; if (observed() !== e) begin errors++; $display("FAIL lb_wb[%0d]: got %h want %h", i, observed(), e); end
            tick();
            dm_data_ok_in = 1'b0;
            #1;
            checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL lb_drain[%0d]: got %b want 0", i, mem_valid_out); end
        end
    endtask

    task automatic test_lw_delay();
        exp_t e;
        issue(32'h0000_2000, 4'b0010, 5'b10000, 8'h0, 32'h0, 32'h0000_0300, 5'd5, 3'd1);
        sb.push_back('{wbdata: 32'hDEAD_BEEF, wnum: 5'd5, wtype: 3'd1, pc: 32'h0000_0300});
        tick();
        exe_valid_in = 1'b0;
        dm_rdata_in  = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_valid_out !== 1'b0 || mem_load_busy_out !== 1'b1 || mem_allowin_out !== 1'b0) begin
                errors++; $display("FAIL lw_wait[%0d]: got valid=%b busy=%b allowin=%b want 0/1/0", i, mem_valid_out, mem_load_busy_out, mem_allowin_out); end
            tick();
        end
        dm_data_ok_in = 1'b1;
        dm_rdata_in   = 32'hDEAD_BEEF;
        #1;
        checks++; if (mem_valid_out !== 1'b1 || mem_load_busy_out !== 1'b0) begin errors++; $display("FAIL lw_done: got valid=%b busy=%b want 1/0", mem_valid_out, mem_load_busy_out); end
        e = sb.pop_front();
        checks++; if (observed() !== e) begin errors++; $display("FAIL lw_wb: got %h want %h", observed(), e); end
        tick();
        dm_data_ok_in = 1'b0;
        #1;
        checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL lw_drain: got %b want 0", mem_valid_out); end
    endtask

    task automatic test_hold();
        exp_t e;
        issue(32'h0000_3004, 4'b0010, 5'b10000, 8'h0, 32'h0, 32'h0000_0400, 5'd6, 3'd3);
        sb.push_back('{wbdata: 32'h1234_5678, wnum: 5'd6, wtype: 3'd3, pc: 32'h0000_0400});
        tick();
        exe_valid_in  = 1'b0;
        wb_allowin_in = 1'b0;
        dm_data_ok_in = 1'b1;
        dm_rdata_in   = 32'h1234_5678;
        #1;
        checks++; if (mem_valid_out !== 1'b1 || mem_allowin_out !== 1'b0 || mem_wbdata_out !== 32'h1234_5678) begin
            errors++; $display("FAIL hold_entry: got valid=%b allowin=%b wb=%h want 1/0/12345678", mem_valid_out, mem_allowin_out, mem_wbdata_out); end
        tick();
        dm_data_ok_in = 1'b0;
        dm_rdata_in   = 32'hBAD0_BAD0;
        issue(32'h0000_5555, 4'b0001, 5'b0, 8'h0, 32'h0, 32'h0000_0500, 5'd8, 3'd1);
        sb.push_back('{wbdata: 32'h0000_5555, wnum: 5'd8, wtype: 3'd1, pc: 32'h0000_0500});
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (mem_valid_out !== 1'b1 || mem_allowin_out !== 1'b0 || mem_load_busy_out !== 1'b0 || mem_wbdata_out !== 32'h1234_5678) begin
                errors++; $display("FAIL hold_stable[%0d]: got valid=%b allowin=%b busy=%b wb=%h want 1/0/0/12345678", i, mem_valid_out, mem_allowin_out, mem_load_busy_out, mem_wbdata_out); end
            tick();
        end
        wb_allowin_in = 1'b1;
        #1;
        checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL hold_release: got allowin=%b want 1", mem_allowin_out); end
        e = sb.pop_front();
        checks++; if (observed() !== e) begin errors++; $display("FAIL hold_wb: got %h want %h", observed(), e); end
        tick();
        exe_valid_in = 1'b0;
        #1;
        e = sb.pop_front();
        checks++; if (mem_valid_out !== 1'b1 || observed() !== e) begin errors++; $display("FAIL hold_next_alu: got valid=%b %h want 1 %h", mem_valid_out, observed(), e); end
        tick();
    endtask

`ifdef MEM_LWLR_EN
    task automatic test_lwlr();
        logic [7:0]  oh   [2];
        logic [31:0] want [2];
        exp_t e;
        oh[0] = 8'b0000_0010; want[0] = 32'h2211_CCDD;
        oh[1] = 8'b0100_0000; want[1] = 32'hAABB_4433;
        for (int i = 0; i < 2; i++) begin
            issue(32'h0000_0601 + 32'(i), 4'b0010, 5'b0, oh[i], 32'hAABB_CCDD, 32'h0000_0600, 5'd10, 3'd1);
            sb.push_back('{wbdata: want[i], wnum: 5'd10, wtype: 3'd1, pc: 32'h0000_0600});
            tick();
            exe_valid_in = 1'b0;
            #1;
            checks++; if (mem_load_busy_out !== 1'b1) begin errors++; $display("FAIL lwlr_busy[%0d]: got %b want 1", i, mem_load_busy_out); end
            dm_data_ok_in = 1'b1;
            dm_rdata_in   = 32'h4433_2211;
            #1;
            e = sb.pop_front();
            checks++; if (mem_valid_out !== 1'b1 || observed() !== e) begin errors++; $display("FAIL lwlr_wb[%0d]: got valid=%b %h want 1 %h", i, mem_valid_out, observed(), e); end
            tick();
            dm_data_ok_in = 1'b0;
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        exp_t e;
        issue(32'h0000_0600, 4'b0010, 5'b10000, 8'h0, 32'h0, 32'h0000_0700, 5'd9, 3'd2);
        tick();
        exe_valid_in = 1'b0;
        #1;
        checks++; if (mem_load_busy_out !== 1'b1) begin errors++; $display("FAIL rstw_busy: got %b want 1", mem_load_busy_out); end
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        dm_data_ok_in = 1'b1;
        dm_rdata_in   = 32'h1111_1111;
        #1;
        checks++; if (mem_valid_out !== 1'b0 || mem_allowin_out !== 1'b1 || mem_load_busy_out !== 1'b0 || mem_wnum_out !== 5'd0 || mem_write_type_out !== 3'd0) begin
            errors++; $display("FAIL rstw_abandon: got valid=%b allowin=%b busy=%b wnum=%0d wtype=%0d want 0/1/0/0/0", mem_valid_out, mem_allowin_out, mem_load_busy_out, mem_wnum_out, mem_write_type_out); end
        tick();
        dm_data_ok_in = 1'b0;
        #1;
        checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL rstw_no_wb: got %b want 0", mem_valid_out); end
        issue(32'h0000_0800, 4'b0010, 5'b10000, 8'h0, 32'h0, 32'h0000_0800, 5'd11, 3'd1);
        sb.push_back('{wbdata: 32'hCAFE_F00D, wnum: 5'd11, wtype: 3'd1, pc: 32'h0000_0800});
        tick();
        exe_valid_in = 1'b0;
        #1;
        checks++; if (mem_valid_out !== 1'b0 || mem_load_busy_out !== 1'b1) begin errors++; $display("FAIL rstw_fresh_wait: got valid=%b busy=%b want 0/1", mem_valid_out, mem_load_busy_out); end
        dm_data_ok_in = 1'b1;
        dm_rdata_in   = 32'hCAFE_F00D;
        #1;
        e = sb.pop_front();
        checks++; if (mem_valid_out !== 1'b1 || observed() !== e) begin errors++; $display("FAIL rstw_fresh_wb: got valid=%b %h want 1 %h", mem_valid_out, observed(), e); end
        tick();
        dm_data_ok_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [4:0]  op_lubhw [N];
        logic [31:0] op_rdata [N];
        logic [31:0] alu;
        logic [31:0] rnd;
        logic        delivered;
        int          k;
        int          cycles;
        exp_t        e;
        for (int i = 0; i < N; i++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            case (kind)
                0:       op_lubhw[i] = 5'b00000;
                1:       op_lubhw[i] = 5'b00001;
                2:       op_lubhw[i] = 5'b00010;
                3:       op_lubhw[i] = 5'b00100;
                4:       op_lubhw[i] = 5'b01000;
                default: op_lubhw[i] = 5'b10000;
            endcase
            op_rdata[i] = $urandom();
        end
        k = 0;
        delivered = 1'b0;
        cycles = 0;
        alu = $urandom();
        issue(alu, (op_lubhw[0] == 5'd0) ? 4'b0001 : 4'b0010, op_lubhw[0], 8'h0, 32'h0,
              32'h0000_1000, 5'd1, 3'd1);
        sb.push_back('{wbdata: (op_lubhw[0] == 5'd0) ? alu : ext_model(op_lubhw[0], alu[1:0], op_rdata[0]),
                       wnum: 5'd1, wtype: 3'd1, pc: 32'h0000_1000});
        tick();
        while (k < N && cycles < 300) begin
            cycles++;
            exe_valid_in  = 1'b0;
            rnd           = $urandom();
            wb_allowin_in = (rnd[1:0] != 2'b00);
            dm_data_ok_in = 1'b0;
            dm_rdata_in   = $urandom();
            if (op_lubhw[k] != 5'd0 && !delivered && rnd[2]) begin
                dm_data_ok_in = 1'b1;
                dm_rdata_in   = op_rdata[k];
                delivered     = 1'b1;
            end
            #1;
            if (mem_valid_out === 1'b1 && wb_allowin_in === 1'b1) begin
                e = sb.pop_front();
                checks++; if (observed() !== e) begin errors++; $display("FAIL b2b_wb[%0d]: got %h want %h", k, observed(), e); end
                k++;
                delivered = 1'b0;
                if (k < N) begin
                    alu = $urandom();
                    issue(alu, (op_lubhw[k] == 5'd0) ? 4'b0001 : 4'b0010, op_lubhw[k], 8'h0, 32'h0,
                          32'h0000_1000 + 32'(k * 4), 5'(k + 1), 3'(k));
                    sb.push_back('{wbdata: (op_lubhw[k] == 5'd0) ? alu : ext_model(op_lubhw[k], alu[1:0], op_rdata[k]),
                                   wnum: 5'(k + 1), wtype: 3'(k), pc: 32'h0000_1000 + 32'(k * 4)});
                end
            end
            tick();
        end
        checks++; if (k != N) begin errors++; $display("FAIL b2b_timeout: got %0d completions want %0d", k, N); end
        idle_inputs();
        sb.delete();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_lw_delay();
        test_hold();
`ifdef MEM_LWLR_EN
        test_lwlr();
`endif
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
